// File: rtl/pll_reconfig_ctrl.sv
// Run-time retune sequencer for the Cyclone V reconfigurable PLL: writes an N/M/C
// profile to the reconfig core over Avalon-MM, starts the update, then waits for a stable lock.
module pll_reconfig_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int C_SEL              = 0
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        locked_sync
);

  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    C_SEL_F   = 5'(C_SEL);

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_START, S_WAIT_LOCK
  } state_e;

  typedef struct packed {
    logic [17:0] n;
    logic [17:0] m;
    logic [17:0] c;
  } profile_t;

  state_e          state_q, state_d;
  profile_t        prof_q, prof_d;
  logic [LW-1:0]   stable_q, stable_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      sync_q, sync_d;
  logic            tmo_hit;

  assign locked_sync = sync_q[1];
  assign cfg_ready   = (state_q == S_IDLE);
  assign busy        = ~cfg_ready;

  always_comb begin
    state_d        = state_q;
    prof_d         = prof_q;
    stable_d       = stable_q;
    tmo_d          = tmo_q;
    sync_d         = {sync_q[0], pll_locked};
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    done           = 1'b0;
    timeout        = 1'b0;
    // Counting the current cycle: the budget is exhausted when tmo_q hits N-1.
    tmo_hit        = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          prof_d.n = cfg_n;
          prof_d.m = cfg_m;
          prof_d.c = cfg_c;
          tmo_d    = '0;
          state_d  = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_MODE;
        if (!mgmt_waitrequest) state_d = S_WR_N;
      end
      S_WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_N;
        mgmt_writedata = {14'b0, prof_q.n};
        if (!mgmt_waitrequest) state_d = S_WR_M;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_M;
        mgmt_writedata = {14'b0, prof_q.m};
        if (!mgmt_waitrequest) state_d = S_WR_C;
      end
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_C;
        mgmt_writedata = {9'b0, C_SEL_F, prof_q.c};
        if (!mgmt_waitrequest) state_d = S_WR_START;
      end
      S_WR_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_START;
        mgmt_writedata = 32'd1;
        if (!mgmt_waitrequest) begin
          stable_d = '0;
          state_d  = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        stable_d = locked_sync ? stable_q + 1'b1 : '0;
        // This cycle's locked sample is the one that completes the stable run.
        if (locked_sync && (stable_q == LOCK_LAST)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) tmo_d = tmo_q + 1'b1;

    // Abort wins over any same-cycle write completion or lock completion.
    if (tmo_hit) begin
      mgmt_write = 1'b0;
      done       = 1'b0;
      timeout    = 1'b1;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prof_q   <= '0;
      stable_q <= '0;
      tmo_q    <= '0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      prof_q   <= prof_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      sync_q   <= sync_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomized bench for pll_reconfig_ctrl: per-request expectations (write list, completion
// cycles, done/timeout cycle) are derived from the lock waveform and stall plan by plain arithmetic.
module tb_pll_reconfig_ctrl;
  localparam int L    = 64;
  localparam int TO   = 200;
  localparam int RLEN = TO + 6;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] cfg_n, cfg_m, cfg_c;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy, done, timeout, locked_sync;

  always #5 refclk = ~refclk;

  pll_reconfig_ctrl #(
    .LOCK_STABLE_CYCLES(L),
    .TIMEOUT_CYCLES(TO),
    .C_SEL(0)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .busy(busy), .done(done), .timeout(timeout),
    .locked_sync(locked_sync)
  );

  int errors = 0;
  int checks = 0;

  // Lock waveform (pll_locked per cycle relative to acceptance), stall plan per write,
  // and the cycle of an extra request pulse while busy (-1 = none).
  bit p[RLEN];
  int stall[5];
  int busy_req_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c);
    logic [5:0]  exp_a[5];
    logic [31:0] exp_d[5];
    int          exp_e[5];
    int          acc, w_ent, run, d, done_exp, tmo_exp, end_exp, n_exp;
    logic [5:0]  obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_e[$];
    int          done_cnt, tmo_cnt, done_at, tmo_at, wi, left;
    logic        pw, pwait, wt;
    logic [5:0]  pa;
    logic [31:0] pd;

    exp_a = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h02};
    exp_d = '{32'd0, {14'b0, n}, {14'b0, m}, {9'b0, 5'd0, c}, 32'd1};
    acc = 0;
    for (int w = 0; w < 5; w++) begin
      acc += stall[w] + 1;
      exp_e[w] = acc;
    end
    w_ent = acc + 1;
    // First cycle closing L consecutive synchronized-high samples inside WAIT_LOCK.
    run = 0;
    d = -1;
    for (int x = w_ent; x < RLEN; x++) begin
      run = p[x-2] ? run + 1 : 0;
      if (run == L) begin
        d = x;
        break;
      end
    end
    if (d >= 0 && d < TO) begin
      done_exp = d; tmo_exp = -1; end_exp = d;
    end else begin
      done_exp = -1; tmo_exp = TO; end_exp = TO;
    end
    n_exp = 0;
    for (int w = 0; w < 5; w++) if (exp_e[w] < end_exp) n_exp++;

    @(negedge refclk);
    chk("ready_before_req", {31'b0, cfg_ready}, 1);
    cfg_valid = 1'b1;
    cfg_n = n; cfg_m = m; cfg_c = c;
    mgmt_waitrequest = 1'b0;
    pll_locked = p[0];

    done_cnt = 0; tmo_cnt = 0; done_at = -1; tmo_at = -1;
    wi = 0; left = stall[0]; pw = 1'b0; pwait = 1'b0; pa = '0; pd = '0;
    for (int r = 1; r < RLEN; r++) begin
      @(negedge refclk);
      cfg_valid = (r == busy_req_r);
      if (r == 1 || r == busy_req_r) begin
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c = 18'($urandom);
      end
      if (r == 1) begin
        chk("busy_after_accept", {31'b0, busy}, 1);
        chk("ready_after_accept", {31'b0, cfg_ready}, 0);
      end
      if (r == end_exp) chk("busy_at_end", {31'b0, busy}, 1);
      if (r == end_exp + 1) begin
        chk("busy_after_end", {31'b0, busy}, 0);
        chk("ready_after_end", {31'b0, cfg_ready}, 1);
      end
      if (r == w_ent && w_ent < end_exp) chk("write_low_wait_lock", {31'b0, mgmt_write}, 0);
      chk("done_timeout_excl", {31'b0, done & timeout}, 0);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = r;
      end
      if (timeout) begin
        tmo_cnt++;
        if (tmo_at < 0) tmo_at = r;
      end
      if (pw && pwait) begin
        chk("stall_write_stable", {31'b0, mgmt_write}, 1);
        chk("stall_addr_stable", {26'b0, mgmt_address}, {26'b0, pa});
        chk("stall_data_stable", mgmt_writedata, pd);
      end
      wt = 1'b0;
      if (mgmt_write && left > 0) begin
        wt = 1'b1;
        left--;
      end
      mgmt_waitrequest = wt;
      if (mgmt_write && !wt) begin
        obs_a.push_back(mgmt_address);
        obs_d.push_back(mgmt_writedata);
        obs_e.push_back(r);
        wi++;
        left = (wi < 5) ? stall[wi] : 0;
      end
      pw = mgmt_write; pa = mgmt_address; pd = mgmt_writedata; pwait = wt;
      pll_locked = p[r];
    end
    cfg_valid = 1'b0;
    mgmt_waitrequest = 1'b0;

    chk("write_count", obs_a.size(), n_exp);
    for (int w = 0; w < n_exp && w < obs_a.size(); w++) begin
      chk($sformatf("wr%0d_addr", w), {26'b0, obs_a[w]}, {26'b0, exp_a[w]});
      chk($sformatf("wr%0d_data", w), obs_d[w], exp_d[w]);
      chk($sformatf("wr%0d_cycle", w), obs_e[w], exp_e[w]);
    end
    chk("done_count", done_cnt, (done_exp >= 0) ? 1 : 0);
    chk("done_cycle", done_at, done_exp);
    chk("timeout_count", tmo_cnt, (tmo_exp >= 0) ? 1 : 0);
    chk("timeout_cycle", tmo_at, tmo_exp);
  endtask

  task automatic fill_lock(input int delay);
    for (int r = 0; r < RLEN; r++) p[r] = (r >= delay);
  endtask

  task automatic no_stall();
    for (int w = 0; w < 5; w++) stall[w] = 0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_c = '0;
    mgmt_waitrequest = 1'b0; pll_locked = 1'b1; busy_req_r = -1;
    repeat (3) @(negedge refclk);
    chk("rst_ready", {31'b0, cfg_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    chk("rst_write", {31'b0, mgmt_write}, 0);
    chk("rst_addr", {26'b0, mgmt_address}, 0);
    chk("rst_data", mgmt_writedata, 0);
    chk("rst_locked_sync", {31'b0, locked_sync}, 0);
    rst = 1'b0;

    // 50 -> 100 MHz profile, no stalls, lock held high.
    no_stall(); fill_lock(0);
    run_txn(18'h00505, 18'h03232, 18'h20302);

    // Three-cycle stall on the M write.
    no_stall(); stall[2] = 3; fill_lock(0);
    run_txn(18'h00505, 18'h03232, 18'h20302);

    // One-cycle lock glitch after 40 stable synchronized cycles.
    no_stall(); fill_lock(0); p[44] = 1'b0;
    run_txn(18'h00404, 18'h01818, 18'h00201);

    // Lock never asserts.
    no_stall(); fill_lock(RLEN);
    run_txn(18'h10101, 18'h20202, 18'h30303);

    // New request while waiting for lock.
    no_stall(); fill_lock(0); busy_req_r = 30;
    run_txn(18'h00606, 18'h02828, 18'h00303);
    busy_req_r = -1;

    // Reset while the N write is stalled.
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_n = 18'h00505; cfg_m = 18'h03232; cfg_c = 18'h20302;
    pll_locked = 1'b1; mgmt_waitrequest = 1'b0;
    @(negedge refclk);
    cfg_valid = 1'b0;
    chk("rstmid_wr_mode_addr", {26'b0, mgmt_address}, 0);
    @(negedge refclk);
    chk("rstmid_wr_n_addr", {26'b0, mgmt_address}, 3);
    mgmt_waitrequest = 1'b1;
    @(negedge refclk);
    chk("rstmid_stalled_write", {31'b0, mgmt_write}, 1);
    rst = 1'b1;
    @(negedge refclk);
    chk("rstmid_write", {31'b0, mgmt_write}, 0);
    chk("rstmid_busy", {31'b0, busy}, 0);
    chk("rstmid_ready", {31'b0, cfg_ready}, 1);
    chk("rstmid_addr", {26'b0, mgmt_address}, 0);
    chk("rstmid_data", mgmt_writedata, 0);
    chk("rstmid_done", {31'b0, done}, 0);
    chk("rstmid_timeout", {31'b0, timeout}, 0);
    chk("rstmid_locked_sync", {31'b0, locked_sync}, 0);
    rst = 1'b0; mgmt_waitrequest = 1'b0;
    no_stall(); fill_lock(0);
    run_txn(18'h00707, 18'h01414, 18'h00505);

    // Randomized profiles, stall plans and lock waveforms.
    for (int k = 0; k < 8; k++) begin
      int ng, idx;
      for (int w = 0; w < 5; w++) stall[w] = $urandom_range(0, 2);
      fill_lock($urandom_range(0, 40));
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        idx = $urandom_range(4, 90);
        p[idx] = 1'b0;
      end
      busy_req_r = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 60) : -1;
      run_txn(18'($urandom), 18'($urandom), 18'($urandom));
    end
    busy_req_r = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that retunes the Cyclone V reconfigurable system PLL at run time. It accepts one counter profile per request: N, M, and one C counter. It writes the profile through the Avalon-MM management port of the PLL reconfiguration core, triggers the reconfiguration, then waits for a stable lock. It sits between host-side control logic and the reconfig core that drives the PLL's 64-bit reconfig_to_pll/reconfig_from_pll buses.

## Interface
- LOCK_STABLE_CYCLES, 64: consecutive synchronized-locked-high cycles required before done.
- TIMEOUT_CYCLES, 100000: maximum cycles from request acceptance to done; exceeding it aborts with timeout.
- C_SEL, 0: C counter index written (bits [22:18] of the C register data).
- refclk  in  1  management clock (50 MHz reference). One clock domain.
- rst  in  1  reset, synchronous and active-high.
- cfg_valid  in  1  profile request.
- cfg_ready  out  1  high only in IDLE; a request is accepted on a cycle where cfg_valid && cfg_ready.
- cfg_n, cfg_m, cfg_c  in  18 each  counter words: [7:0] lo count, [15:8] hi count, [16] bypass, [17] odd-divide duty enable.
- mgmt_address  out  6  reconfig core register address.
- mgmt_writedata  out  32  write data.
- mgmt_write  out  1  write strobe.
- mgmt_waitrequest  in  1  core stall.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse on successful relock.
- timeout  out  1  one-cycle pulse on abort.
- locked_sync  out  1  pll_locked after a 2-flop synchronizer.

## Operation
- The block latches cfg_n, cfg_m and cfg_c on acceptance. Later input changes are ignored until the next acceptance.
- State sequence: IDLE -> WR_MODE -> WR_N -> WR_M -> WR_C -> WR_START -> WAIT_LOCK -> IDLE.
- Writes per state (address, data):
  - WR_MODE: 0x00, 0 (waitrequest mode).
  - WR_N: 0x03, {14'b0, n}.
  - WR_M: 0x04, {14'b0, m}.
  - WR_C: 0x05, {9'b0, C_SEL[4:0], c}.
  - WR_START: 0x02, 1.
- Avalon rules:
  - mgmt_write, mgmt_address and mgmt_writedata stay stable while mgmt_waitrequest is high.
  - A write completes on the edge where mgmt_write=1 and mgmt_waitrequest=0. The FSM advances on that same edge.
  - No idle cycle is inserted between writes.
  - mgmt_write is low in IDLE and in WAIT_LOCK.
- WAIT_LOCK:
  - A stable counter increments on each cycle with locked_sync=1 and clears to 0 on any cycle with locked_sync=0.
  - When the count reaches LOCK_STABLE_CYCLES, the block pulses done and returns to IDLE.
- Timeout:
  - A timeout counter clears on acceptance and increments on every non-IDLE cycle, including write stalls.
  - When it reaches TIMEOUT_CYCLES, the block deasserts mgmt_write, pulses timeout and returns to IDLE.
  - Timeout takes priority over a same-cycle write completion or stable-count completion.
- cfg_valid while busy is ignored. It is not queued.

## Timing
- Reset values:
  - cfg_ready=1, busy=0, done=0, timeout=0.
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0.
  - locked_sync=0; synchronizer flops = 0.
  - Both counters = 0; state = IDLE.
- Reset mid-operation: all outputs take reset values on the next edge, including an in-progress mgmt_write. The reconfig core shares rst, so this abort is legal. No done or timeout is emitted.
- Acceptance at edge T: busy=1 and cfg_ready=0 from T+1. WR_MODE is driven from T+1.
- With mgmt_waitrequest always 0:
  - Writes occupy cycles T+1 through T+5.
  - WAIT_LOCK is entered at T+6.
  - Each waitrequest-high cycle adds one cycle.
- locked_sync lags pll_locked by 2 cycles.
- If locked_sync is already high on entry to WAIT_LOCK: done is high in cycle T+5+LOCK_STABLE_CYCLES, and busy=0 and cfg_ready=1 in the following cycle.
- done and timeout never assert together, and each pulse lasts exactly 1 cycle.

## Test plan
- 50→100 MHz profile: cfg_n=0x00505, cfg_m=0x03232, cfg_c=0x20302, waitrequest=0, locked held high -> writes (0x00,0), (0x03,0x505), (0x04,0x3232), (0x05,0x20302), (0x02,1) in 5 consecutive cycles; done exactly 64 cycles after WAIT_LOCK entry.
- Waitrequest stretch: hold waitrequest high for 3 cycles during WR_M -> address 0x04 and data 0x3232 stay stable for 4 cycles; total write phase 8 cycles; done is still produced.
- Lock glitch: locked high 40 cycles, low 1 cycle, then high -> stable count restarts; done arrives 64 cycles after the glitch clears, as seen through the synchronizer.
- Lock never asserts, TIMEOUT_CYCLES=200 -> timeout pulse once, 200 cycles after acceptance; no done; cfg_ready=1 the next cycle.
- Reset mid-write: assert rst during WR_N while waitrequest=1 -> next edge mgmt_write=0, busy=0, state IDLE; a new request then restarts at WR_MODE.
- Request while busy: pulse cfg_valid with different values during WAIT_LOCK -> ignored; latched values unchanged; exactly one done.
